// File: rtl/ddr2_init_seq_if.sv
// ddr2_init_seq_if: command bus between the DDR2 init sequencer and the PHY mux.
// master = sequencer side, slave = controller/PHY side.
interface ddr2_init_seq_if #(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 14
);
    logic                 init_req;
    logic                 init_cke;
    logic [3:0]           init_cmd;
    logic [BA_BITS-1:0]   init_ba;
    logic [ADDR_BITS-1:0] init_addr;
    logic                 init_busy;
    logic                 init_done;

    modport master (
        input  init_req,
        output init_cke,
        output init_cmd,
        output init_ba,
        output init_addr,
        output init_busy,
        output init_done
    );

    modport slave (
        output init_req,
        input  init_cke,
        input  init_cmd,
        input  init_ba,
        input  init_addr,
        input  init_busy,
        input  init_done
    );
endinterface

// File: rtl/ddr2_init_seq.sv
// ddr2_init_seq: parametrised DDR2 power-up/initialisation sequencer.
// Define DDR2_INIT_OCD_EN to insert the OCD default/exit EMR1 pair.
module ddr2_init_seq #(
    parameter int BA_BITS     = 3,
    parameter int ADDR_BITS   = 14,
    parameter int T_PWRUP_CYC = 60000,
    parameter int T_CKE_CYC   = 100,
    parameter int T_RP_CYC    = 3,
    parameter int T_MRD_CYC   = 2,
    parameter int T_RFC_CYC   = 26,
    parameter int NUM_AREF    = 2,
    parameter int T_DLLK_CYC  = 200,
    parameter logic [ADDR_BITS-1:0] MR_VAL   = 14'h0432,
    parameter logic [ADDR_BITS-1:0] EMR1_VAL = 14'h0010,
    parameter logic [ADDR_BITS-1:0] EMR2_VAL = '0,
    parameter logic [ADDR_BITS-1:0] EMR3_VAL = '0
) (
    input logic             clk,
    input logic             rst_n,
    ddr2_init_seq_if.master bus
);
    localparam int T_M1  = (T_PWRUP_CYC > T_CKE_CYC) ? T_PWRUP_CYC : T_CKE_CYC;
    localparam int T_M2  = (T_RP_CYC > T_MRD_CYC) ? T_RP_CYC : T_MRD_CYC;
    localparam int T_M3  = (T_RFC_CYC > T_DLLK_CYC) ? T_RFC_CYC : T_DLLK_CYC;
    localparam int T_M4  = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int T_MAX = (T_M4 > T_M3) ? T_M4 : T_M3;
    localparam int CW    = $clog2(T_MAX) + 1;
    localparam int AW    = $clog2(NUM_AREF) + 1;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LM   = 4'b0000;

    localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] A10       = ONE << 10;
    localparam logic [ADDR_BITS-1:0] MR_DLL    = MR_VAL | (ONE << 8);
    localparam logic [ADDR_BITS-1:0] MR_RUN    = MR_VAL & ~(ONE << 8);
    localparam logic [ADDR_BITS-1:0] OCD_MASK  = ADDR_BITS'(7) << 7;
    localparam logic [ADDR_BITS-1:0] EMR1_EXIT = EMR1_VAL & ~ONE & ~OCD_MASK;
    localparam logic [ADDR_BITS-1:0] EMR1_DEF  = EMR1_EXIT | OCD_MASK;

    if (NUM_AREF < 2) begin : g_bad_aref
        $error("NUM_AREF must be at least 2");
    end
    if (T_PWRUP_CYC < 1 || T_CKE_CYC < 1 || T_RP_CYC < 1 ||
        T_MRD_CYC < 1 || T_RFC_CYC < 1) begin : g_bad_gap
        $error("all gap parameters must be at least 1");
    end

    typedef enum logic [3:0] {
        S_PWRUP, S_CKE_WAIT, S_EMR2, S_EMR3, S_EMR1, S_MRDLL, S_PRE2,
        S_AREF, S_MR, S_OCD_DEF, S_OCD_EXIT, S_DLL_WAIT, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, gap_q, gap_d, dll_q, dll_d;
    logic [AW-1:0]        aref_q, aref_d;
    logic                 cke_q, cke_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [BA_BITS-1:0]   ba_q, ba_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 gap_met, go;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        aref_d  = aref_q;
        cke_d   = cke_q;
        cmd_d   = CMD_NOP;
        ba_d    = ba_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        gap_met = cnt_q >= gap_q;
        cnt_d   = gap_met ? cnt_q : cnt_q + 1'b1;
        dll_d   = (dll_q < CW'(T_DLLK_CYC)) ? dll_q + 1'b1 : dll_q;
        go      = gap_met;
        if (state_q == S_DLL_WAIT) go = gap_met && (dll_q >= CW'(T_DLLK_CYC));
        if (state_q == S_DONE)     go = bus.init_req;
        // cnt restarts at 1 on the issuing edge so it reads k exactly k cycles later
        if (go) begin
            cnt_d = CW'(1);
            unique case (state_q)
                S_PWRUP: begin
                    cke_d   = 1'b1;
                    gap_d   = CW'(T_CKE_CYC);
                    state_d = S_CKE_WAIT;
                end
                S_CKE_WAIT, S_DONE: begin
                    cmd_d   = CMD_PRE;
                    ba_d    = '0;
                    addr_d  = A10;
                    gap_d   = CW'(T_RP_CYC);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_EMR2;
                end
                S_EMR2: begin
                    cmd_d   = CMD_LM;
                    ba_d    = BA_BITS'(2);
                    addr_d  = EMR2_VAL;
                    gap_d   = CW'(T_MRD_CYC);
                    state_d = S_EMR3;
                end
                S_EMR3: begin
                    cmd_d   = CMD_LM;
                    ba_d    = BA_BITS'(3);
                    addr_d  = EMR3_VAL;
                    gap_d   = CW'(T_MRD_CYC);
                    state_d = S_EMR1;
                end
                S_EMR1: begin
                    cmd_d   = CMD_LM;
                    ba_d    = BA_BITS'(1);
                    addr_d  = EMR1_EXIT;
                    gap_d   = CW'(T_MRD_CYC);
                    state_d = S_MRDLL;
                end
                S_MRDLL: begin
                    cmd_d   = CMD_LM;
                    ba_d    = '0;
                    addr_d  = MR_DLL;
                    gap_d   = CW'(T_MRD_CYC);
                    dll_d   = CW'(1);
                    state_d = S_PRE2;
                end
                S_PRE2: begin
                    cmd_d   = CMD_PRE;
                    ba_d    = '0;
                    addr_d  = A10;
                    gap_d   = CW'(T_RP_CYC);
                    aref_d  = '0;
                    state_d = S_AREF;
                end
                S_AREF: begin
                    cmd_d = CMD_AREF;
                    gap_d = CW'(T_RFC_CYC);
                    if (aref_q == AW'(NUM_AREF - 1)) begin
                        aref_d  = '0;
                        state_d = S_MR;
                    end else begin
                        aref_d = aref_q + 1'b1;
                    end
                end
                S_MR: begin
                    cmd_d  = CMD_LM;
                    ba_d   = '0;
                    addr_d = MR_RUN;
                    gap_d  = CW'(T_MRD_CYC);
`ifdef DDR2_INIT_OCD_EN
                    state_d = S_OCD_DEF;
`else
                    state_d = S_OCD_EXIT;
`endif
                end
                S_OCD_DEF: begin
                    cmd_d   = CMD_LM;
                    ba_d    = BA_BITS'(1);
                    addr_d  = EMR1_DEF;
                    gap_d   = CW'(T_MRD_CYC);
                    state_d = S_OCD_EXIT;
                end
                S_OCD_EXIT: begin
                    cmd_d   = CMD_LM;
                    ba_d    = BA_BITS'(1);
                    addr_d  = EMR1_EXIT;
                    gap_d   = CW'(T_MRD_CYC);
                    state_d = S_DLL_WAIT;
                end
                S_DLL_WAIT: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            gap_q   <= CW'(T_PWRUP_CYC);
            dll_q   <= '0;
            aref_q  <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dll_q   <= dll_d;
            aref_q  <= aref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.init_cke  = cke_q;
    assign bus.init_cmd  = cmd_q;
    assign bus.init_ba   = ba_q;
    assign bus.init_addr = addr_q;
    assign bus.init_busy = busy_q;
    assign bus.init_done = done_q;
endmodule

// File: tb/tb_ddr2_init_seq.sv
// tb_ddr2_init_seq: table-driven timeline checks for ddr2_init_seq.
// dut0 uses T_DLLK_CYC=200, dut1 uses T_DLLK_CYC=10.
module tb_ddr2_init_seq;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LM   = 4'b0000;

`ifdef DDR2_INIT_OCD_EN
    localparam int N_EV  = 12;
    localparam int DONE1 = 96;
`else
    localparam int N_EV  = 11;
    localparam int DONE1 = 94;
`endif
    localparam int DONE0 = 233;
    localparam int REOFF = 277;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        int         ba;
        logic [13:0] addr;
    } ev_t;

    ev_t ev [N_EV];
    int  checks = 0;
    int  errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ddr2_init_seq_if #(.BA_BITS(3), .ADDR_BITS(14)) bus0 ();
    ddr2_init_seq_if #(.BA_BITS(3), .ADDR_BITS(14)) bus1 ();

    ddr2_init_seq #(
        .T_PWRUP_CYC(20), .T_CKE_CYC(4), .T_RP_CYC(3), .T_MRD_CYC(2),
        .T_RFC_CYC(26), .NUM_AREF(2), .T_DLLK_CYC(200)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    ddr2_init_seq #(
        .T_PWRUP_CYC(20), .T_CKE_CYC(4), .T_RP_CYC(3), .T_MRD_CYC(2),
        .T_RFC_CYC(26), .NUM_AREF(2), .T_DLLK_CYC(10)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " cke"},  32'(bus0.init_cke), 0);
        chk({tag, " cmd"},  32'(bus0.init_cmd), 32'(NOP));
        chk({tag, " ba"},   32'(bus0.init_ba), 0);
        chk({tag, " addr"}, 32'(bus0.init_addr), 0);
        chk({tag, " busy"}, 32'(bus0.init_busy), 1);
        chk({tag, " done"}, 32'(bus0.init_done), 0);
    endtask

    // Checks dut0 outputs at cycle n against the event table shifted by off.
    task automatic chk_cycle(input int n, input int off, input bit cke_e,
                             input bit done_e);
        logic [3:0] cmd_e;
        int         hit;
        string      t;
        cmd_e = NOP;
        hit   = -1;
        for (int i = 0; i < N_EV; i++)
            if (ev[i].cyc + off == n) begin
                hit   = i;
                cmd_e = ev[i].cmd;
            end
        t = $sformatf("c%0d", n);
        chk({t, " cmd"},  32'(bus0.init_cmd), 32'(cmd_e));
        chk({t, " cke"},  32'(bus0.init_cke), 32'(cke_e));
        chk({t, " done"}, 32'(bus0.init_done), 32'(done_e));
        chk({t, " busy"}, 32'(bus0.init_busy), 32'(!done_e));
        if (hit >= 0 && cmd_e == LM) begin
            chk({t, " ba"},   32'(bus0.init_ba), 32'(ev[hit].ba));
            chk({t, " addr"}, 32'(bus0.init_addr), 32'(ev[hit].addr));
        end
        if (hit >= 0 && cmd_e == PRE)
            chk({t, " a10"}, 32'(bus0.init_addr[10]), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset("rst_now");
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst_hold");
        bus0.init_req = 1'b0;
        bus1.init_req = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        ev[0]  = '{24, PRE,  0, 14'h0400};
        ev[1]  = '{27, LM,   2, 14'h0000};
        ev[2]  = '{29, LM,   3, 14'h0000};
        ev[3]  = '{31, LM,   1, 14'h0010};
        ev[4]  = '{33, LM,   0, 14'h0532};
        ev[5]  = '{35, PRE,  0, 14'h0400};
        ev[6]  = '{38, AREF, 0, 14'h0000};
        ev[7]  = '{64, AREF, 0, 14'h0000};
        ev[8]  = '{90, LM,   0, 14'h0432};
`ifdef DDR2_INIT_OCD_EN
        ev[9]  = '{92, LM,   1, 14'h0390};
        ev[10] = '{94, LM,   1, 14'h0010};
        ev[11] = '{0,  NOP,  0, 14'h0000};
`else
        ev[9]  = '{92, LM,   1, 14'h0010};
        ev[10] = '{0,  NOP,  0, 14'h0000};
`endif
        bus0.init_req = 1'b0;
        bus1.init_req = 1'b0;

        // Run A: clean power-up, both DLL-lock settings
        repeat (2) @(posedge clk);
        do_reset();
        for (int n = 0; n <= 240; n++) begin
            @(posedge clk);
            #1;
            chk_cycle(n, 0, n >= 20, n >= DONE0);
            chk($sformatf("d1 c%0d done", n), 32'(bus1.init_done),
                32'(n >= DONE1));
            if (n == 28) begin
                chk("hold ba c28",   32'(bus0.init_ba), 2);
                chk("hold addr c28", 32'(bus0.init_addr), 0);
            end
        end

        // Run B: request while busy ignored, request at 300 re-inits
        do_reset();
        for (int n = 0; n <= 515; n++) begin
            @(posedge clk);
            #1;
            if (n < 300)
                chk_cycle(n, 0, n >= 20, n >= DONE0);
            else
                chk_cycle(n, REOFF, 1'b1, n == 300 || n >= 510);
            bus0.init_req = (n == 40 || n == 300);
        end

        // Run C: reset asserted mid-sequence at cycle 50
        do_reset();
        for (int n = 0; n <= 50; n++) begin
            @(posedge clk);
            #1;
            chk_cycle(n, 0, n >= 20, 1'b0);
        end
        do_reset();
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk);
            #1;
            chk_cycle(n, 0, n >= 20, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
